// File: rtl/ahb_arbiter_pkg.sv
// Shared AHB encodings, burst-length helper and arbiter state type for the
// multi-master arbiter slice.
package ahb_arbiter_pkg;

  typedef enum logic [1:0] {
    TRANS_IDLE   = 2'b00,
    TRANS_BUSY   = 2'b01,
    TRANS_NONSEQ = 2'b10,
    TRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    BURST_SINGLE = 3'b000,
    BURST_INCR   = 3'b001,
    BURST_WRAP4  = 3'b010,
    BURST_INCR4  = 3'b011,
    BURST_WRAP8  = 3'b100,
    BURST_INCR8  = 3'b101,
    BURST_WRAP16 = 3'b110,
    BURST_INCR16 = 3'b111
  } hburst_e;

  typedef enum logic [1:0] {
    RESP_OKAY  = 2'b00,
    RESP_ERROR = 2'b01,
    RESP_RETRY = 2'b10,
    RESP_SPLIT = 2'b11
  } hresp_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BURST,
    ST_INCR,
    ST_LOCKED
  } arb_state_e;

  // Undefined-length INCR counts as one beat; its extent is tracked by a flag.
  function automatic logic [4:0] burst_len(input logic [2:0] hburst);
    case (hburst)
      BURST_WRAP4,  BURST_INCR4:  return 5'd4;
      BURST_WRAP8,  BURST_INCR8:  return 5'd8;
      BURST_WRAP16, BURST_INCR16: return 5'd16;
      default:                    return 5'd1;
    endcase
  endfunction

endpackage

// File: rtl/ahb_arbiter_if.sv
// Arbiter-facing bus signals: requests, muxed owner controls, global response
// and the registered grant/owner outputs.
interface ahb_arbiter_if #(
  parameter int NUM_MASTERS = 4
);
  localparam int IW = $clog2(NUM_MASTERS);

  logic [NUM_MASTERS-1:0] HBUSREQ;
  logic [NUM_MASTERS-1:0] HLOCK;
  logic [1:0]             HTRANS;
  logic [2:0]             HBURST;
  logic                   HREADY;
  logic [1:0]             HRESP;
  logic [NUM_MASTERS-1:0] HGRANT;
  logic [IW-1:0]          HMASTER;
  logic                   HMASTLOCK;

  modport slave (
    input  HBUSREQ, HLOCK, HTRANS, HBURST, HREADY, HRESP,
    output HGRANT, HMASTER, HMASTLOCK
  );

  modport master (
    output HBUSREQ, HLOCK, HTRANS, HBURST, HREADY, HRESP,
    input  HGRANT, HMASTER, HMASTLOCK
  );

endinterface

// File: rtl/ahb_arb_picker.sv
// Combinational next-winner selector: round robin from ptr+1, or lowest index
// first when fixed_prio is set; DEFAULT_MASTER when nobody requests.
module ahb_arb_picker #(
  parameter  int NUM_MASTERS    = 4,
  parameter  int DEFAULT_MASTER = 0,
  localparam int IW             = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [IW-1:0]          ptr,
  input  logic                   fixed_prio,
  output logic [IW-1:0]          winner
);

  logic [IW-1:0] cand;

  // Loops run from the lowest-priority candidate up so the highest-priority
  // requester is the last to write winner.
  always_comb begin
    winner = IW'(DEFAULT_MASTER);
    cand   = '0;
    if (fixed_prio) begin
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
        if (req[IW'(i)]) winner = IW'(i);
      end
    end else begin
      for (int k = NUM_MASTERS; k >= 1; k--) begin
        cand = IW'((int'(ptr) + k) % NUM_MASTERS);
        if (req[cand]) winner = cand;
      end
    end
  end

endmodule

// File: rtl/ahb_arbiter.sv
// Multi-master AHB arbiter; hands over only at legal burst boundaries.
// Define AHB_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round robin.
module ahb_arbiter
  import ahb_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0
) (
  input logic           HCLK,
  input logic           HRESETn,
  ahb_arbiter_if.slave  bus
);

  localparam int IW = $clog2(NUM_MASTERS);
  localparam logic [IW-1:0] DEF_IDX = IW'(DEFAULT_MASTER);

  logic [4:0]             rem_q, rem_nxt;
  logic                   incr_q, incr_nxt;
  logic [NUM_MASTERS-1:0] grant_q, grant_nxt;
  logic [IW-1:0]          gnt_idx_q;
  logic [IW-1:0]          hmaster_q;
  logic                   hmastlock_q;
  logic                   owner_lock, owner_req;
  arb_state_e             state_nxt;
  logic                   arb_open;
  logic [IW-1:0]          pick_idx;
  logic [IW-1:0]          rr_ptr;
  logic                   fixed_prio;

`ifdef AHB_ARB_FIXED_PRIO_EN
  assign fixed_prio = 1'b1;
  assign rr_ptr     = '0;
`else
  // The address-phase owner doubles as the round-robin pointer.
  assign fixed_prio = 1'b0;
  assign rr_ptr     = hmaster_q;
`endif

  ahb_arb_picker #(
    .NUM_MASTERS    (NUM_MASTERS),
    .DEFAULT_MASTER (DEFAULT_MASTER)
  ) u_picker (
    .req        (bus.HBUSREQ),
    .ptr        (rr_ptr),
    .fixed_prio (fixed_prio),
    .winner     (pick_idx)
  );

  // Post-beat counter/flag values, the bus state they imply, and whether this
  // beat is a legal handover point.
  always_comb begin
    rem_nxt  = rem_q;
    incr_nxt = incr_q;
    case (bus.HTRANS)
      TRANS_NONSEQ: begin
        rem_nxt  = burst_len(bus.HBURST) - 5'd1;
        incr_nxt = (bus.HBURST == BURST_INCR);
      end
      TRANS_SEQ: begin
        if (rem_q != 5'd0) rem_nxt = rem_q - 5'd1;
      end
      TRANS_IDLE: begin
        rem_nxt  = 5'd0;
        incr_nxt = 1'b0;
      end
      default: ;
    endcase
    if (bus.HRESP == RESP_ERROR) begin
      rem_nxt  = 5'd0;
      incr_nxt = 1'b0;
    end

    owner_lock = bus.HLOCK[hmaster_q];
    owner_req  = bus.HBUSREQ[hmaster_q];

    if (owner_lock)             state_nxt = ST_LOCKED;
    else if (rem_nxt != 5'd0)   state_nxt = ST_BURST;
    else if (incr_nxt)          state_nxt = ST_INCR;
    else                        state_nxt = ST_IDLE;

    arb_open = (state_nxt == ST_IDLE) ||
               ((state_nxt == ST_INCR) && !owner_req);

    grant_nxt           = '0;
    grant_nxt[pick_idx] = 1'b1;
  end

  // Nothing moves on a wait state; HMASTER/HMASTLOCK trail the grant by one beat.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rem_q       <= 5'd0;
      incr_q      <= 1'b0;
      grant_q     <= '0;
      grant_q[DEF_IDX] <= 1'b1;
      gnt_idx_q   <= DEF_IDX;
      hmaster_q   <= DEF_IDX;
      hmastlock_q <= 1'b0;
    end else if (bus.HREADY) begin
      rem_q  <= rem_nxt;
      incr_q <= incr_nxt;
      if (arb_open) begin
        grant_q   <= grant_nxt;
        gnt_idx_q <= pick_idx;
      end
      hmaster_q   <= gnt_idx_q;
      hmastlock_q <= bus.HLOCK[gnt_idx_q];
    end
  end

  assign bus.HGRANT    = grant_q;
  assign bus.HMASTER   = hmaster_q;
  assign bus.HMASTLOCK = hmastlock_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Self-checking bench for ahb_arbiter (4 masters, default master 0):
// vector table with a scoreboard queue plus hand-written reset sequences.
module tb_ahb_arbiter;
  import ahb_arbiter_pkg::*;

  typedef struct {
    bit         rst;
    int         scen;
    logic [3:0] req;
    logic [3:0] lock;
    logic [1:0] trans;
    logic [2:0] burst;
    logic       ready;
    logic [1:0] resp;
    logic [3:0] g;
    logic [1:0] m;
    logic       l;
  } vec_t;

  typedef struct {
    logic [3:0] g;
    logic [1:0] m;
    logic       l;
  } exp_t;

  logic HCLK;
  logic HRESETn;

  ahb_arbiter_if #(.NUM_MASTERS(4)) bus ();

  ahb_arbiter #(
    .NUM_MASTERS    (4),
    .DEFAULT_MASTER (0)
  ) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  vec_t vecs[$];
  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t v(input bit rst, input int scen,
                             input logic [3:0] req, input logic [3:0] lock,
                             input logic [1:0] trans, input logic [2:0] burst,
                             input logic ready, input logic [1:0] resp,
                             input logic [3:0] g, input logic [1:0] m,
                             input logic l);
    vec_t r;
    r.rst = rst; r.scen = scen; r.req = req; r.lock = lock;
    r.trans = trans; r.burst = burst; r.ready = ready; r.resp = resp;
    r.g = g; r.m = m; r.l = l;
    return r;
  endfunction

  function automatic exp_t e(input logic [3:0] g, input logic [1:0] m, input logic l);
    exp_t r;
    r.g = g; r.m = m; r.l = l;
    return r;
  endfunction

  task automatic driveBus(input logic [3:0] req, input logic [3:0] lock,
                          input logic [1:0] trans, input logic [2:0] burst,
                          input logic ready, input logic [1:0] resp);
    bus.HBUSREQ = req;
    bus.HLOCK   = lock;
    bus.HTRANS  = trans;
    bus.HBURST  = burst;
    bus.HREADY  = ready;
    bus.HRESP   = resp;
  endtask

  task automatic checkOutput(input string tag);
    exp_t x;
    if (sb.size() == 0) begin
      total++; bad++;
      $display("[TB] FAIL %s scoreboard: got empty queue want one entry", tag);
      return;
    end
    x = sb.pop_front();
    total++;
    if (bus.HGRANT !== x.g) begin
      bad++;
      $display("[TB] FAIL %s HGRANT: got %b want %b", tag, bus.HGRANT, x.g);
    end
    total++;
    if (bus.HMASTER !== x.m) begin
      bad++;
      $display("[TB] FAIL %s HMASTER: got %0d want %0d", tag, bus.HMASTER, x.m);
    end
    total++;
    if (bus.HMASTLOCK !== x.l) begin
      bad++;
      $display("[TB] FAIL %s HMASTLOCK: got %b want %b", tag, bus.HMASTLOCK, x.l);
    end
  endtask

  task automatic doReset(input string tag);
    @(negedge HCLK);
    HRESETn = 1'b0;
    driveBus(4'b0000, 4'b0000, TRANS_IDLE, BURST_SINGLE, 1'b1, RESP_OKAY);
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    HRESETn = 1'b1;
    #1;
    sb.push_back(e(4'b0001, 2'd0, 1'b0));
    checkOutput(tag);
  endtask

  task automatic applyStimulus(input vec_t r, input string tag);
    @(negedge HCLK);
    driveBus(r.req, r.lock, r.trans, r.burst, r.ready, r.resp);
    sb.push_back(e(r.g, r.m, r.l));
    @(posedge HCLK);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    HRESETn = 1'b0;
    driveBus(4'b0000, 4'b0000, TRANS_IDLE, BURST_SINGLE, 1'b1, RESP_OKAY);

    // 0: reset hold with no requests
    vecs.push_back(v(1, 0, 4'b0000, 4'b0000, TRANS_IDLE, BURST_SINGLE, 1, RESP_OKAY, 4'b0001, 2'd0, 0));
    for (int i = 0; i < 9; i++)
      vecs.push_back(v(0, 0, 4'b0000, 4'b0000, TRANS_IDLE, BURST_SINGLE, 1, RESP_OKAY, 4'b0001, 2'd0, 0));
    // 1: M1 and M2 request together, M1 does a SINGLE and drops
    vecs.push_back(v(1, 1, 4'b0110, 4'b0000, TRANS_IDLE,   BURST_SINGLE, 1, RESP_OKAY, 4'b0010, 2'd0, 0));
    vecs.push_back(v(0, 1, 4'b0110, 4'b0000, TRANS_IDLE,   BURST_SINGLE, 1, RESP_OKAY, 4'b0010, 2'd1, 0));
    vecs.push_back(v(0, 1, 4'b0100, 4'b0000, TRANS_NONSEQ, BURST_SINGLE, 1, RESP_OKAY, 4'b0100, 2'd1, 0));
    vecs.push_back(v(0, 1, 4'b0100, 4'b0000, TRANS_IDLE,   BURST_SINGLE, 1, RESP_OKAY, 4'b0100, 2'd2, 0));
    vecs.push_back(v(0, 1, 4'b0000, 4'b0000, TRANS_NONSEQ, BURST_SINGLE, 1, RESP_OKAY, 4'b0001, 2'd2, 0));
    vecs.push_back(v(0, 1, 4'b0000, 4'b0000, TRANS_IDLE,   BURST_SINGLE, 1, RESP_OKAY, 4'b0001, 2'd0, 0));
    // 2: M1 INCR4, M3 requests during beat 1
    vecs.push_back(v(1, 2, 4'b0010, 4'b0000, TRANS_IDLE,   BURST_SINGLE, 1, RESP_OKAY, 4'b0010, 2'd0, 0));
    vecs.push_back(v(0, 2, 4'b0010, 4'b0000, TRANS_IDLE,   BURST_SINGLE, 1, RESP_OKAY, 4'b0010, 2'd1, 0));
    vecs.push_back(v(0, 2, 4'b1010, 4'b0000, TRANS_NONSEQ, BURST_INCR4,  1, RESP_OKAY, 4'b0010, 2'd1, 0));
    vecs.push_back(v(0, 2, 4'b1010, 4'b0000, TRANS_SEQ,    BURST_INCR4,  1, RESP_OKAY, 4'b0010, 2'd1, 0));
    vecs.push_back(v(0, 2, 4'b1010, 4'b0000, TRANS_SEQ,    BURST_INCR4,  1, RESP_OKAY, 4'b0010, 2'd1, 0));
    vecs.push_back(v(0, 2, 4'b1010, 4'b0000, TRANS_SEQ,    BURST_INCR4,  1, RESP_OKAY, 4'b1000, 2'd1, 0));
    vecs.push_back(v(0, 2, 4'b1000, 4'b0000, TRANS_IDLE,   BURST_SINGLE, 1, RESP_OKAY, 4'b1000, 2'd3, 0));
    // 3: same burst with three wait states on the last beat
    vecs.push_back(v(1, 3, 4'b0010, 4'b0000, TRANS_IDLE,   BURST_SINGLE, 1, RESP_OKAY, 4'b0010, 2'd0, 0));
    vecs.push_back(v(0, 3, 4'b0010, 4'b0000, TRANS_IDLE,   BURST_SINGLE, 1, RESP_OKAY, 4'b0010, 2'd1, 0));
    vecs.push_back(v(0, 3, 4'b1010, 4'b0000, TRANS_NONSEQ, BURST_INCR4,  1, RESP_OKAY, 4'b0010, 2'd1, 0));
    vecs.push_back(v(0, 3, 4'b1010, 4'b0000, TRANS_SEQ,    BURST_INCR4,  1, RESP_OKAY, 4'b0010, 2'd1, 0));
    vecs.push_back(v(0, 3, 4'b1010, 4'b0000, TRANS_SEQ,    BURST_INCR4,  1, RESP_OKAY, 4'b0010, 2'd1, 0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(v(0, 3, 4'b1010, 4'b0000, TRANS_SEQ,  BURST_INCR4,  0, RESP_OKAY, 4'b0010, 2'd1, 0));
    vecs.push_back(v(0, 3, 4'b1010, 4'b0000, TRANS_SEQ,    BURST_INCR4,  1, RESP_OKAY, 4'b1000, 2'd1, 0));
    vecs.push_back(v(0, 3, 4'b1000, 4'b0000, TRANS_IDLE,   BURST_SINGLE, 1, RESP_OKAY, 4'b1000, 2'd3, 0));
    // 4: M2 locked SINGLEs with M0 requesting
    vecs.push_back(v(1, 4, 4'b0100, 4'b0100, TRANS_IDLE,   BURST_SINGLE, 1, RESP_OKAY, 4'b0100, 2'd0, 0));
    vecs.push_back(v(0, 4, 4'b0101, 4'b0100, TRANS_IDLE,   BURST_SINGLE, 1, RESP_OKAY, 4'b0100, 2'd2, 1));
    vecs.push_back(v(0, 4, 4'b0101, 4'b0100, TRANS_NONSEQ, BURST_SINGLE, 1, RESP_OKAY, 4'b0100, 2'd2, 1));
    vecs.push_back(v(0, 4, 4'b0101, 4'b0100, TRANS_NONSEQ, BURST_SINGLE, 1, RESP_OKAY, 4'b0100, 2'd2, 1));
    vecs.push_back(v(0, 4, 4'b0001, 4'b0000, TRANS_NONSEQ, BURST_SINGLE, 1, RESP_OKAY, 4'b0001, 2'd2, 0));
    vecs.push_back(v(0, 4, 4'b0001, 4'b0000, TRANS_IDLE,   BURST_SINGLE, 1, RESP_OKAY, 4'b0001, 2'd0, 0));
    // 5: M1 INCR8 hit by ERROR on beat 3 while M2 requests
    vecs.push_back(v(1, 5, 4'b0010, 4'b0000, TRANS_IDLE,   BURST_SINGLE, 1, RESP_OKAY,  4'b0010, 2'd0, 0));
    vecs.push_back(v(0, 5, 4'b0010, 4'b0000, TRANS_IDLE,   BURST_SINGLE, 1, RESP_OKAY,  4'b0010, 2'd1, 0));
    vecs.push_back(v(0, 5, 4'b0110, 4'b0000, TRANS_NONSEQ, BURST_INCR8,  1, RESP_OKAY,  4'b0010, 2'd1, 0));
    vecs.push_back(v(0, 5, 4'b0110, 4'b0000, TRANS_SEQ,    BURST_INCR8,  1, RESP_OKAY,  4'b0010, 2'd1, 0));
    vecs.push_back(v(0, 5, 4'b0110, 4'b0000, TRANS_SEQ,    BURST_INCR8,  1, RESP_ERROR, 4'b0100, 2'd1, 0));
    vecs.push_back(v(0, 5, 4'b0100, 4'b0000, TRANS_IDLE,   BURST_SINGLE, 1, RESP_OKAY,  4'b0100, 2'd2, 0));
    // 6: undefined-length INCR held while M1 requests, released when it drops
    vecs.push_back(v(1, 6, 4'b0010, 4'b0000, TRANS_IDLE,   BURST_SINGLE, 1, RESP_OKAY, 4'b0010, 2'd0, 0));
    vecs.push_back(v(0, 6, 4'b0010, 4'b0000, TRANS_IDLE,   BURST_SINGLE, 1, RESP_OKAY, 4'b0010, 2'd1, 0));
    vecs.push_back(v(0, 6, 4'b1010, 4'b0000, TRANS_NONSEQ, BURST_INCR,   1, RESP_OKAY, 4'b0010, 2'd1, 0));
    vecs.push_back(v(0, 6, 4'b1010, 4'b0000, TRANS_SEQ,    BURST_INCR,   1, RESP_OKAY, 4'b0010, 2'd1, 0));
    vecs.push_back(v(0, 6, 4'b1000, 4'b0000, TRANS_SEQ,    BURST_INCR,   1, RESP_OKAY, 4'b1000, 2'd1, 0));
    vecs.push_back(v(0, 6, 4'b1000, 4'b0000, TRANS_IDLE,   BURST_SINGLE, 1, RESP_OKAY, 4'b1000, 2'd3, 0));
    // 7: INCR4 with BUSY beats, which must not count down
    vecs.push_back(v(1, 7, 4'b0010, 4'b0000, TRANS_IDLE,   BURST_SINGLE, 1, RESP_OKAY, 4'b0010, 2'd0, 0));
    vecs.push_back(v(0, 7, 4'b0010, 4'b0000, TRANS_IDLE,   BURST_SINGLE, 1, RESP_OKAY, 4'b0010, 2'd1, 0));
    vecs.push_back(v(0, 7, 4'b0110, 4'b0000, TRANS_NONSEQ, BURST_INCR4,  1, RESP_OKAY, 4'b0010, 2'd1, 0));
    vecs.push_back(v(0, 7, 4'b0110, 4'b0000, TRANS_BUSY,   BURST_INCR4,  1, RESP_OKAY, 4'b0010, 2'd1, 0));
    vecs.push_back(v(0, 7, 4'b0110, 4'b0000, TRANS_SEQ,    BURST_INCR4,  1, RESP_OKAY, 4'b0010, 2'd1, 0));
    vecs.push_back(v(0, 7, 4'b0110, 4'b0000, TRANS_SEQ,    BURST_INCR4,  1, RESP_OKAY, 4'b0010, 2'd1, 0));
    vecs.push_back(v(0, 7, 4'b0110, 4'b0000, TRANS_BUSY,   BURST_INCR4,  1, RESP_OKAY, 4'b0010, 2'd1, 0));
    vecs.push_back(v(0, 7, 4'b0110, 4'b0000, TRANS_SEQ,    BURST_INCR4,  1, RESP_OKAY, 4'b0100, 2'd1, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) doReset($sformatf("scen%0d reset", vecs[i].scen));
      applyStimulus(vecs[i], $sformatf("scen%0d row%0d", vecs[i].scen, i));
    end

    // Asynchronous reset in the middle of an INCR4 with M3 pending.
    doReset("async pre");
    applyStimulus(v(0, 8, 4'b0010, 4'b0000, TRANS_IDLE,   BURST_SINGLE, 1, RESP_OKAY, 4'b0010, 2'd0, 0), "async setup0");
    applyStimulus(v(0, 8, 4'b0010, 4'b0000, TRANS_IDLE,   BURST_SINGLE, 1, RESP_OKAY, 4'b0010, 2'd1, 0), "async setup1");
    applyStimulus(v(0, 8, 4'b1010, 4'b0000, TRANS_NONSEQ, BURST_INCR4,  1, RESP_OKAY, 4'b0010, 2'd1, 0), "async beat1");
    @(negedge HCLK);
    #2;
    HRESETn = 1'b0;
    #1;
    sb.push_back(e(4'b0001, 2'd0, 1'b0));
    checkOutput("async midcycle");
    // A BUSY right after reset opens only if the beat counter was cleared.
    driveBus(4'b0010, 4'b0000, TRANS_BUSY, BURST_INCR4, 1'b1, RESP_OKAY);
    @(negedge HCLK);
    HRESETn = 1'b1;
    sb.push_back(e(4'b0010, 2'd0, 1'b0));
    @(posedge HCLK);
    #1;
    checkOutput("async rem cleared");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ahb_arbiter.md
# ahb_arbiter

Multi-master AHB bus arbiter. It decides which of N masters drives the shared address/control bus that feeds the slave decoder and SRAM slave. Ownership is handed over only at legal AHB boundaries: idle bus, last beat of a fixed-length burst, release of an undefined-length INCR, or an ERROR-terminated burst. It produces HGRANT, and the registered HMASTER and HMASTLOCK that drive the address/write-data mux.

## Interface
Parameters:
- NUM_MASTERS, 4: number of requesters, 2..8.
- DEFAULT_MASTER, 0: master granted when nobody requests; also the reset owner.

Ports:
- HCLK, in, 1: bus clock.
- HRESETn, in, 1: reset, asynchronous, active-low.
- HBUSREQ, in, NUM_MASTERS: per-master bus request.
- HLOCK, in, NUM_MASTERS: per-master locked-transfer request.
- HTRANS, in, 2: muxed transfer type of the current owner.
- HBURST, in, 3: muxed burst type of the current owner.
- HREADY, in, 1: global ready from the slave-response mux.
- HRESP, in, 2: global response.
- HGRANT, out, NUM_MASTERS: one-hot grant, registered.
- HMASTER, out, clog2(NUM_MASTERS): address-phase owner index, registered.
- HMASTLOCK, out, 1: current address phase is locked, registered.

## Operation
- An accepted beat is a rising edge with HREADY=1. At each accepted beat, the remaining-beat counter `rem` (5 bits) updates as follows:
  - HTRANS=NONSEQ: `rem` is loaded with len-1. len is 1 for SINGLE, 4 for INCR4/WRAP4, 8 for INCR8/WRAP8, 16 for INCR16/WRAP16. For INCR (undefined length), len=1 and the `incr_active` flag is set.
  - HTRANS=SEQ: `rem` decrements, saturating at 0.
  - HTRANS=IDLE: `rem` and `incr_active` are cleared.
  - HTRANS=BUSY: `rem` is held.
- HRESP=ERROR at an accepted edge clears `rem` and `incr_active`.
- `arb_open` is true when all of the following hold at an accepted edge, using post-update values:
  - `rem`=0;
  - HLOCK[owner]=0;
  - not (`incr_active` and HBUSREQ[owner]=1).
- State machine, with states derived from the counter and flags:
  - IDLE: `rem`=0 and arbitration is open.
  - BURST: `rem`>0.
  - INCR: `incr_active`=1.
  - LOCKED: HLOCK[owner]=1.
  - Transitions happen only on accepted edges.
- Arbitration runs when `arb_open` is true and HGRANT loads the winner:
  - Round robin: the search starts at owner+1 and wraps modulo NUM_MASTERS.
  - If no HBUSREQ is asserted, HGRANT = DEFAULT_MASTER.
  - If the current owner is the only requester, it keeps the grant.
- HGRANT is unchanged at edges where `arb_open` is false, and at any edge with HREADY=0.
- HMASTER is loaded with the index of HGRANT at each HREADY=1 edge.
- HMASTLOCK is loaded with HLOCK[granted index] at each HREADY=1 edge.
- Simultaneous requests resolve in one arbitration. Requests that arrive mid-burst wait for the next open point. Dropping HBUSREQ mid fixed burst does not end ownership early.

## Timing
- Reset values:
  - HGRANT = one-hot(DEFAULT_MASTER);
  - HMASTER = DEFAULT_MASTER;
  - HMASTLOCK = 0;
  - `rem` = 0, `incr_active` = 0;
  - round-robin pointer = DEFAULT_MASTER.
- Request to grant: HBUSREQ sampled at edge E on an open, idle bus gives HGRANT valid after E (1 cycle). HMASTER follows at the next HREADY=1 edge.
- Handover gap: the last beat of the old owner is accepted at edge E, HGRANT changes at E, and HMASTER changes at E+1. The old master drives IDLE in the cycle between E and E+1. This single idle cycle is required; the new master's NONSEQ is issued after E+1.
- Wait states stretch everything: no counter, grant or HMASTER update happens while HREADY=0.
- Reset asserted mid-burst forces all outputs to their reset values immediately (asynchronous).

## Configuration
- AHB_ARB_FIXED_PRIO_EN:
  - Defined: fixed priority, where the lowest-index requester wins at every open point and the pointer logic is removed.
  - Undefined (default): round robin as described above.
- Both builds use identical handover points.

## Structure
- HTRANS, HBURST and HRESP encodings and a burst-length function belong in the shared AHB macro/package (ahb_macro_h.v). They are not redefined locally.
- One sub-module: ahb_arb_picker, a combinational next-winner selector that takes request vector, pointer and mode.
- The burst counter, flags and output registers live in ahb_arbiter.

## Test plan
- Reset with no requests: HGRANT=0001, HMASTER=0, HMASTLOCK=0, and they stay so for 10 cycles.
- Idle bus, M1 and M2 request together: HGRANT=0010 after 1 edge. After M1 issues a SINGLE and drops its request, HGRANT=0100, with HMASTER=1 and then HMASTER=2 at successive HREADY edges.
- M1 runs INCR4 and M3 requests during beat 1: HGRANT stays 0010 through beat 3. It becomes 1000 at the 4th accepted beat, and HMASTER=3 one HREADY edge later.
- HREADY held low for 3 cycles on the last INCR4 beat: no change to HGRANT until the edge where HREADY=1.
- M2 issues locked SINGLE transfers (HLOCK[2]=1) with M0 requesting: no handover and HMASTLOCK=1. One accepted edge after HLOCK[2] drops, HGRANT=0001.
- INCR8 by M1 gets HRESP=ERROR on beat 3 while M2 requests: `rem` clears and HGRANT=0100 at that accepted edge.
